// File: rtl/error_vec_gen_pkg.sv
// Shared types and sizing helpers for the ROLLO-I error vector generator.
// Default sizes match the small configuration used in bring-up.
package error_vec_gen_pkg;

    localparam int N_DEF = 7;
    localparam int M_DEF = 8;
    localparam int R_DEF = 3;
    localparam int D_DEF = 5;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        GEN,
        FLUSH,
        DONE
    } gen_state_t;

    // Never returns less than 1 so that a size-1 range still gets a real bit.
    function automatic int clog2_w(input int v);
        int w;
        w = 1;
        while ((1 << w) < v) w++;
        return w;
    endfunction

    function automatic int row_depth(input int n, input int d);
        return n / d + (((n % d) != 0) ? 1 : 0);
    endfunction

endpackage

// File: rtl/error_vec_gen_if.sv
// Bus between the error vector generator, its basis RAM, the random source
// and the e RAM.
interface error_vec_gen_if #(
    parameter int N = error_vec_gen_pkg::N_DEF,
    parameter int M = error_vec_gen_pkg::M_DEF,
    parameter int R = error_vec_gen_pkg::R_DEF,
    parameter int D = error_vec_gen_pkg::D_DEF
);
    import error_vec_gen_pkg::*;

    localparam int WIDTH = M * D;
    localparam int DEPTH = row_depth(N, D);
    localparam int E_AW  = clog2_w(R);
    localparam int e_AW  = clog2_w(2 * DEPTH);

    logic             start;
    logic             finish;
    logic [E_AW-1:0]  E_addr;
    logic [M-1:0]     E_din;
    logic             rnd_valid;
    logic [R-1:0]     rnd_data;
    logic             rnd_ready;
    logic [e_AW-1:0]  e_addr;
    logic [WIDTH-1:0] e_dout;
    logic             e_we;

    modport slave (
        input  start, E_din, rnd_valid, rnd_data,
        output finish, E_addr, rnd_ready, e_addr, e_dout, e_we
    );

    modport master (
        output start, E_din, rnd_valid, rnd_data,
        input  finish, E_addr, rnd_ready, e_addr, e_dout, e_we
    );

endinterface

// File: rtl/gf2m_span_comb.sv
// GF(2) linear combination of an r-element basis of GF(2^m) elements;
// addition in GF(2^m) is plain XOR, so no reduction is involved.
module gf2m_span_comb #(
    parameter int M = 8,
    parameter int R = 3
) (
    input  logic [R-1:0][M-1:0] basis,
    input  logic [R-1:0]        sel,
    output logic [M-1:0]        span
);

    always_comb begin
        span = '0;
        for (int i = 0; i < R; i++) begin
            if (sel[i]) span = span ^ basis[i];
        end
    end

endmodule

// File: rtl/error_vec_gen.sv
// Loads the error support basis, then turns 2n random coefficient words into
// packed e1/e2 rows in the same row layout the gf2mz multiplier reads.
module error_vec_gen
    import error_vec_gen_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int M = M_DEF,
    parameter int R = R_DEF,
    parameter int D = D_DEF
) (
    input  logic           clk,
    input  logic           rst_b,
    error_vec_gen_if.slave bus
);

    localparam int WIDTH = M * D;
    localparam int DEPTH = row_depth(N, D);
    localparam int E_AW  = clog2_w(R);
    localparam int e_AW  = clog2_w(2 * DEPTH);
    localparam int CW    = clog2_w(R + 1);
    localparam int SW    = clog2_w(D);
    localparam int JW    = clog2_w(N);

    gen_state_t          state;
    gen_state_t          state_nxt;
    logic [CW-1:0]       load_cnt;
    logic [R-1:0][M-1:0] basis;
    logic [WIDTH-1:0]    pack;
    logic [WIDTH-1:0]    pack_nxt;
    logic [SW-1:0]       slot;
    logic [JW-1:0]       vec_pos;
    logic                second_half;
    logic [e_AW-1:0]     row;
    logic [M-1:0]        elem;
    logic                consume;
    logic                row_done;
    logic                last_coord;
    logic                e_we_q;
    logic [e_AW-1:0]     e_addr_q;
    logic [WIDTH-1:0]    e_dout_q;

    gf2m_span_comb #(.M(M), .R(R)) u_span (
        .basis (basis),
        .sel   (bus.rnd_data),
        .span  (elem)
    );

    assign consume    = (state == GEN) && bus.rnd_valid;
    assign row_done   = (slot == SW'(D - 1)) || (vec_pos == JW'(N - 1));
    assign last_coord = second_half && (vec_pos == JW'(N - 1));

    assign bus.rnd_ready = (state == GEN);
    assign bus.finish    = (state == DONE);
    assign bus.E_addr    = ((state == LOAD) && (load_cnt < CW'(R))) ? E_AW'(load_cnt) : '0;
    assign bus.e_we      = e_we_q;
    assign bus.e_addr    = e_addr_q;
    assign bus.e_dout    = e_dout_q;

    always_ff @(posedge clk) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_nxt;
    end

    // LOAD runs one cycle past the last address so the final RAM word lands.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = LOAD;
            LOAD:    if (load_cnt == CW'(R)) state_nxt = GEN;
            GEN:     if (consume && last_coord) state_nxt = FLUSH;
            FLUSH:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b)              load_cnt <= '0;
        else if (state == LOAD)  load_cnt <= load_cnt + 1'b1;
        else                     load_cnt <= '0;
    end

    always_ff @(posedge clk) begin
        if (state == LOAD) begin
            for (int k = 0; k < R; k++) begin
                if (load_cnt == CW'(k + 1)) basis[k] <= bus.E_din;
            end
        end
    end

    always_comb begin
        pack_nxt = pack;
        for (int k = 0; k < D; k++) begin
            if (slot == SW'(k)) pack_nxt[M*k +: M] = elem;
        end
    end

    // e2 begins on a fresh row because the tail of e1 always closes its row.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            pack        <= '0;
            slot        <= '0;
            vec_pos     <= '0;
            second_half <= 1'b0;
            row         <= '0;
            e_we_q      <= 1'b0;
            e_addr_q    <= '0;
            e_dout_q    <= '0;
        end else begin
            e_we_q   <= 1'b0;
            e_addr_q <= '0;
            e_dout_q <= '0;
            if (state == IDLE) begin
                pack        <= '0;
                slot        <= '0;
                vec_pos     <= '0;
                second_half <= 1'b0;
                row         <= '0;
            end else if (consume) begin
                if (row_done) begin
                    e_we_q   <= 1'b1;
                    e_addr_q <= row;
                    e_dout_q <= pack_nxt;
                    pack     <= '0;
                    slot     <= '0;
                    row      <= row + 1'b1;
                end else begin
                    pack <= pack_nxt;
                    slot <= slot + 1'b1;
                end
                if (vec_pos == JW'(N - 1)) begin
                    vec_pos     <= '0;
                    second_half <= 1'b1;
                end else begin
                    vec_pos <= vec_pos + 1'b1;
                end
            end
        end
    end

endmodule
